// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
package fifo_pkg;

    typedef enum logic {RD_REG, RD_FWFT} rd_mode_e;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake, threshold and status bundle of sync_fifo_prog; clock and reset stay outside.
interface sync_fifo_prog_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 4
);
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [CNT_W-1:0]  af_thresh;
    logic [CNT_W-1:0]  ae_thresh;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;
    logic              overflow;
    logic              underflow;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
        input  full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        output data_out, rd_valid, wr_ack, overflow, underflow,
        output full, empty, almost_full, almost_empty, count
    );
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with explicit wrap, so DEPTH need not be a power of two.
module fifo_wrap_ptr #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end
endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with any depth, live almost-full/empty thresholds, flush,
// occupancy output and either registered or first-word-fall-through reads.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned FWFT   = 0
) (
    input logic            clk,
    input logic            rst_n,
    sync_fifo_prog_if.slave bus
);
    localparam int unsigned CNT_W   = cnt_w(DEPTH);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam rd_mode_e    RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, rd_ok, wr_ok;
    logic              wr_ack_q, overflow_q, underflow_q;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Acceptance uses pre-edge occupancy; a read frees a slot for a write into a full FIFO.
    always_comb begin
        rd_ok   = bus.rd_en && !empty;
        wr_ok   = bus.wr_en && (!full || rd_ok);
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .inc   (wr_ok),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .inc   (rd_ok),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush && wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ack_q    <= wr_ok;
            overflow_q  <= bus.wr_en && !wr_ok;
            underflow_q <= bus.rd_en && !rd_ok;
        end
    end

    generate
        if (RD_MODE == RD_FWFT) begin : g_fwft
            // Head word is undefined while empty; consumers qualify with rd_valid.
            assign bus.data_out = mem[rd_ptr];
            assign bus.rd_valid = !empty;
        end else begin : g_reg
            logic [DATA_W-1:0] data_out_q;
            logic              rd_valid_q;

            // Flush drops rd_valid but keeps the last word on data_out.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_out_q <= '0;
                    rd_valid_q <= 1'b0;
                end else if (bus.flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) begin
                        data_out_q <= mem[rd_ptr];
                    end
                end
            end

            assign bus.data_out = data_out_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);
    assign bus.wr_ack       = wr_ack_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: DEPTH=5 registered-read and FWFT instances, vector table
// plus scoreboard for read data, and hand-written flush/reset/threshold sequences.
module tb_sync_fifo_prog;
    localparam int unsigned DW = 16;
    localparam int unsigned DP = 5;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sync_fifo_prog_if #(.DATA_W(DW), .CNT_W(CW)) bus_r ();
    sync_fifo_prog_if #(.DATA_W(DW), .CNT_W(CW)) bus_f ();

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r)
    );

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] last_read = '0;

    // fl = {full, empty, wr_ack, overflow, underflow, almost_full, almost_empty, rd_valid}
    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        logic [CW-1:0] cnt;
        logic [7:0]    fl;
        logic          chk_do;
        logic [DW-1:0] exp_do;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the scoreboard for every word the registered-read instance presents.
    task automatic sb_check(input string name);
        if (bus_r.rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk({name, "_sb_empty"}, 32'(bus_r.data_out), 32'hDEAD_BEEF);
            end else begin
                last_read = sb.pop_front();
                chk({name, "_data"}, 32'(bus_r.data_out), 32'(last_read));
            end
        end
    endtask

    task automatic r_cycle(input logic w, input logic r, input logic [DW-1:0] d,
                           input logic exp_acc, input string name);
        bus_r.wr_en   = w;
        bus_r.rd_en   = r;
        bus_r.data_in = d;
        if (exp_acc) sb.push_back(d);
        step();
        bus_r.wr_en = 1'b0;
        bus_r.rd_en = 1'b0;
        sb_check(name);
    endtask

    function automatic logic [7:0] flags_r();
        return {bus_r.full, bus_r.empty, bus_r.wr_ack, bus_r.overflow, bus_r.underflow,
                bus_r.almost_full, bus_r.almost_empty, bus_r.rd_valid};
    endfunction

    initial begin
        //          w     r     d        cnt   fl            chk  exp_do
        vecs[0]  = '{1'b1, 1'b0, 16'hA0, 3'd1, 8'b0010_0010, 1'b0, 16'h0};
        vecs[1]  = '{1'b1, 1'b0, 16'hA1, 3'd2, 8'b0010_0000, 1'b0, 16'h0};
        vecs[2]  = '{1'b1, 1'b0, 16'hA2, 3'd3, 8'b0010_0000, 1'b0, 16'h0};
        vecs[3]  = '{1'b1, 1'b0, 16'hA3, 3'd4, 8'b0010_0100, 1'b0, 16'h0};
        vecs[4]  = '{1'b1, 1'b0, 16'hA4, 3'd5, 8'b1010_0100, 1'b0, 16'h0};
        vecs[5]  = '{1'b1, 1'b0, 16'hA5, 3'd5, 8'b1001_0100, 1'b0, 16'h0};
        vecs[6]  = '{1'b0, 1'b0, 16'h00, 3'd5, 8'b1000_0100, 1'b0, 16'h0};
        vecs[7]  = '{1'b0, 1'b1, 16'h00, 3'd4, 8'b0000_0101, 1'b0, 16'h0};
        vecs[8]  = '{1'b0, 1'b1, 16'h00, 3'd3, 8'b0000_0001, 1'b0, 16'h0};
        vecs[9]  = '{1'b0, 1'b1, 16'h00, 3'd2, 8'b0000_0001, 1'b0, 16'h0};
        vecs[10] = '{1'b0, 1'b1, 16'h00, 3'd1, 8'b0000_0011, 1'b0, 16'h0};
        vecs[11] = '{1'b0, 1'b1, 16'h00, 3'd0, 8'b0100_0011, 1'b0, 16'h0};
        vecs[12] = '{1'b0, 1'b1, 16'h00, 3'd0, 8'b0100_1010, 1'b1, 16'hA4};
        vecs[13] = '{1'b1, 1'b0, 16'h10, 3'd1, 8'b0010_0010, 1'b0, 16'h0};
        vecs[14] = '{1'b1, 1'b0, 16'h11, 3'd2, 8'b0010_0000, 1'b0, 16'h0};
        vecs[15] = '{1'b1, 1'b0, 16'h12, 3'd3, 8'b0010_0000, 1'b0, 16'h0};
        vecs[16] = '{1'b1, 1'b0, 16'h13, 3'd4, 8'b0010_0100, 1'b0, 16'h0};
        vecs[17] = '{1'b1, 1'b0, 16'h14, 3'd5, 8'b1010_0100, 1'b0, 16'h0};
        vecs[18] = '{1'b1, 1'b1, 16'hB0, 3'd5, 8'b1010_0101, 1'b0, 16'h0};
        vecs[19] = '{1'b0, 1'b1, 16'h00, 3'd4, 8'b0000_0101, 1'b0, 16'h0};
        vecs[20] = '{1'b0, 1'b1, 16'h00, 3'd3, 8'b0000_0001, 1'b0, 16'h0};
        vecs[21] = '{1'b0, 1'b1, 16'h00, 3'd2, 8'b0000_0001, 1'b0, 16'h0};
        vecs[22] = '{1'b0, 1'b1, 16'h00, 3'd1, 8'b0000_0011, 1'b0, 16'h0};
        vecs[23] = '{1'b0, 1'b1, 16'h00, 3'd0, 8'b0100_0011, 1'b0, 16'h0};
        vecs[24] = '{1'b1, 1'b1, 16'hB1, 3'd1, 8'b0010_1010, 1'b0, 16'h0};
        vecs[25] = '{1'b0, 1'b1, 16'h00, 3'd0, 8'b0100_0011, 1'b0, 16'h0};

        rst_n = 1'b0;
        bus_r.flush = 1'b0; bus_r.wr_en = 1'b0; bus_r.rd_en = 1'b0; bus_r.data_in = '0;
        bus_r.af_thresh = 3'd4; bus_r.ae_thresh = 3'd1;
        bus_f.flush = 1'b0; bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0; bus_f.data_in = '0;
        bus_f.af_thresh = 3'd4; bus_f.ae_thresh = 3'd1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_count", 32'(bus_r.count), 32'd0);
        chk("rst_flags", 32'(flags_r()), 32'b0100_0010);
        chk("rst_dout", 32'(bus_r.data_out), 32'h0);
        bus_r.af_thresh = 3'd0;
        #1;
        chk("af_thresh0", 32'(bus_r.almost_full), 32'd1);
        bus_r.af_thresh = 3'd4;

        // Fill, overflow, drain, underflow, full/empty simultaneous access
        for (int i = 0; i < 26; i++) begin
            r_cycle(vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].w && vecs[i].fl[5],
                    $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_count", i), 32'(bus_r.count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_flags", i), 32'(flags_r()), 32'(vecs[i].fl));
            if (vecs[i].chk_do) begin
                chk($sformatf("vec%0d_hold", i), 32'(bus_r.data_out), 32'(vecs[i].exp_do));
            end
        end

        // Pointer wrap at constant occupancy 3
        for (int k = 0; k < 3; k++) r_cycle(1'b1, 1'b0, 16'(k), 1'b1, "wrap_fill");
        for (int k = 3; k < 20; k++) begin
            r_cycle(1'b1, 1'b1, 16'(k), 1'b1, "wrap");
            chk($sformatf("wrap%0d_count", k), 32'(bus_r.count), 32'd3);
        end
        for (int k = 0; k < 3; k++) r_cycle(1'b0, 1'b1, '0, 1'b0, "wrap_drain");
        chk("wrap_sb_drained", 32'(sb.size()), 32'd0);
        chk("wrap_empty", 32'(bus_r.empty), 32'd1);

        // Threshold edges at full
        for (int k = 0; k < 5; k++) r_cycle(1'b1, 1'b0, 16'h60 + 16'(k), 1'b1, "thr_fill");
        bus_r.ae_thresh = 3'd5;
        #1;
        chk("ae_thresh_depth", 32'(bus_r.almost_empty), 32'd1);
        bus_r.ae_thresh = 3'd4;
        #1;
        chk("ae_thresh_below", 32'(bus_r.almost_empty), 32'd0);
        bus_r.ae_thresh = 3'd1;

        // FWFT instance
        chk("fwft_rst_empty", 32'(bus_f.empty), 32'd1);
        chk("fwft_rst_valid", 32'(bus_f.rd_valid), 32'd0);
        bus_f.wr_en = 1'b1; bus_f.data_in = 16'hC1;
        step();
        bus_f.wr_en = 1'b0;
        chk("fwft_valid", 32'(bus_f.rd_valid), 32'd1);
        chk("fwft_dout_c1", 32'(bus_f.data_out), 32'hC1);
        bus_f.rd_en = 1'b1;
        step();
        bus_f.rd_en = 1'b0;
        chk("fwft_empty", 32'(bus_f.empty), 32'd1);
        chk("fwft_valid_low", 32'(bus_f.rd_valid), 32'd0);
        bus_f.wr_en = 1'b1; bus_f.data_in = 16'hC2;
        step();
        bus_f.data_in = 16'hC3;
        step();
        bus_f.wr_en = 1'b0;
        chk("fwft_dout_c2", 32'(bus_f.data_out), 32'hC2);
        bus_f.rd_en = 1'b1;
        step();
        bus_f.rd_en = 1'b0;
        chk("fwft_dout_c3", 32'(bus_f.data_out), 32'hC3);
        chk("fwft_count", 32'(bus_f.count), 32'd1);

        // Flush at count 3 with a concurrent write
        r_cycle(1'b0, 1'b1, '0, 1'b0, "pre_flush");
        r_cycle(1'b0, 1'b1, '0, 1'b0, "pre_flush");
        chk("pre_flush_count", 32'(bus_r.count), 32'd3);
        bus_r.flush = 1'b1; bus_r.wr_en = 1'b1; bus_r.data_in = 16'h77;
        step();
        bus_r.flush = 1'b0; bus_r.wr_en = 1'b0;
        sb.delete();
        chk("flush_count", 32'(bus_r.count), 32'd0);
        chk("flush_empty", 32'(bus_r.empty), 32'd1);
        chk("flush_wr_ack", 32'(bus_r.wr_ack), 32'd0);
        chk("flush_valid", 32'(bus_r.rd_valid), 32'd0);
        chk("flush_dout_held", 32'(bus_r.data_out), 32'(last_read));

        // Reset in the middle of a burst
        r_cycle(1'b1, 1'b0, 16'h55, 1'b1, "burst");
        r_cycle(1'b1, 1'b1, 16'h56, 1'b1, "burst");
        chk("burst_valid", 32'(bus_r.rd_valid), 32'd1);
        rst_n = 1'b0; bus_r.wr_en = 1'b1; bus_r.rd_en = 1'b1; bus_r.data_in = 16'h57;
        step();
        sb.delete();
        chk("mid_rst_count", 32'(bus_r.count), 32'd0);
        chk("mid_rst_flags", 32'(flags_r()), 32'b0100_0010);
        chk("mid_rst_dout", 32'(bus_r.data_out), 32'h0);
        rst_n = 1'b1; bus_r.wr_en = 1'b0; bus_r.rd_en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
